// File: rtl/mux_rr_arbiter_pkg.sv
// Shared definitions for the four-way round-robin mux arbiter.
package mux_rr_arbiter_pkg;

  localparam int ARB_N = 4;
  localparam int SEL_W = 2;

  // state    | meaning
  // ST_IDLE  | no grant outstanding, G=0, V=0
  // ST_GRANT | one requester owns the shared line, selected by S
  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } arb_state_e;

  // One-hot decode of a select index.
  function automatic logic [ARB_N-1:0] sel_onehot(input logic [SEL_W-1:0] idx);
    return ARB_N'(1) << idx;
  endfunction

  // First set bit of mask scanning start, start+1, ... with wrap.
  // Scanning backwards and overwriting leaves the nearest hit.
  // Callers only use the result when mask is non-zero.
  function automatic logic [SEL_W-1:0] first_from(input logic [ARB_N-1:0] mask,
                                                  input logic [SEL_W-1:0] start);
    logic [SEL_W-1:0] idx;
    logic [SEL_W-1:0] res;
    res = start;
    for (int k = ARB_N - 1; k >= 0; k--) begin
      idx = start + SEL_W'(k);
      if (mask[idx]) res = idx;
    end
    return res;
  endfunction

endpackage

// File: rtl/mux_4to1_bh.sv
// Behavioural 4-to-1 single-bit multiplexer.
module mux_4to1_bh (
  input  logic [3:0] d,
  input  logic [1:0] s,
  output logic       y
);

  // Select one data bit by index.
  always_comb begin
    y = d[s];
  end

endmodule

// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter sharing one 4:1 bit mux between four requesters,
// with a bounded tenure whenever another requester is waiting.
module mux_rr_arbiter
  import mux_rr_arbiter_pkg::*;
#(
  parameter int MAX_HOLD = 8,
  parameter int CNT_W    = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [ARB_N-1:0] R,
  input  logic [ARB_N-1:0] I,
  output logic [SEL_W-1:0] S,
  output logic [ARB_N-1:0] G,
  output logic             V,
  output logic             Y
);

  arb_state_e       state_q, state_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic [ARB_N-1:0] grant_q, grant_d;
  logic             valid_q, valid_d;
  logic [SEL_W-1:0] ptr_q, ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [ARB_N-1:0] others;
  logic             rel_hit;
  logic             expire_hit;
  logic [SEL_W-1:0] win;
  logic [SEL_W-1:0] next_idx;
  logic             mux_y;

  // Next-state: grant from idle, hand off on release/expiry, else hold.
  always_comb begin
    state_d    = state_q;
    sel_d      = sel_q;
    grant_d    = grant_q;
    valid_d    = valid_q;
    ptr_d      = ptr_q;
    cnt_d      = cnt_q;
    win        = '0;
    next_idx   = sel_q + SEL_W'(1);
    others     = R & ~sel_onehot(sel_q);
    rel_hit    = ~R[sel_q];
    expire_hit = (cnt_q == CNT_W'(MAX_HOLD)) && (|others);

    unique case (state_q)
      ST_IDLE: begin
        if (|R) begin
          win     = first_from(R, ptr_q);
          sel_d   = win;
          grant_d = sel_onehot(win);
          valid_d = 1'b1;
          cnt_d   = CNT_W'(1);
          state_d = ST_GRANT;
        end
      end
      ST_GRANT: begin
        if (rel_hit || expire_hit) begin
          // The outgoing grantee drops to lowest priority.
          ptr_d = next_idx;
          if (|others) begin
            win     = first_from(others, next_idx);
            sel_d   = win;
            grant_d = sel_onehot(win);
            cnt_d   = CNT_W'(1);
          end else begin
            grant_d = '0;
            valid_d = 1'b0;
            cnt_d   = '0;
            state_d = ST_IDLE;
          end
        end else if (cnt_q != CNT_W'(MAX_HOLD)) begin
          // Saturate so an uncontested grant is never revoked.
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Registered grant state with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      sel_q   <= '0;
      grant_q <= '0;
      valid_q <= 1'b0;
      ptr_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      grant_q <= grant_d;
      valid_q <= valid_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
    end
  end

  mux_4to1_bh u_mux (
    .d(I),
    .s(sel_q),
    .y(mux_y)
  );

  assign S = sel_q;
  assign G = grant_q;
  assign V = valid_q;
  assign Y = mux_y & valid_q;

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Self-checking bench: directed scenarios plus random traffic against a
// behavioural round-robin model.
module tb_mux_rr_arbiter;

  localparam int MH = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] R   = 4'b0000;
  logic [3:0] I   = 4'b0000;
  logic [1:0] S;
  logic [3:0] G;
  logic       V;
  logic       Y;

  int n_cmp = 0;
  int n_err = 0;

  mux_rr_arbiter #(.MAX_HOLD(MH), .CNT_W(4)) dut (
    .clk(clk),
    .rst(rst),
    .R(R),
    .I(I),
    .S(S),
    .G(G),
    .V(V),
    .Y(Y)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int         m_owner;   // current owner index, meaningful when m_busy
  bit         m_busy;
  int         m_next;    // requester that gets first look next search
  int         m_tenure;  // cycles owned so far (capped at MH)
  logic [3:0] m_rest;

  function automatic int pick(input logic [3:0] req, input int start);
    for (int k = 0; k < 4; k++)
      if (req[(start + k) % 4]) return (start + k) % 4;
    return -1;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_owner = 0; m_busy = 0; m_next = 0; m_tenure = 0;
    end else if (!m_busy) begin
      if (R != 4'b0000) begin
        m_owner = pick(R, m_next); m_busy = 1; m_tenure = 1;
      end
    end else begin
      m_rest = R;
      m_rest[m_owner] = 1'b0;
      if (!R[m_owner] || (m_tenure >= MH && m_rest != 4'b0000)) begin
        m_next = (m_owner + 1) % 4;
        if (m_rest != 4'b0000) begin
          m_owner = pick(m_rest, m_next); m_tenure = 1;
        end else begin
          m_busy = 0; m_tenure = 0;
        end
      end else if (m_tenure < MH) begin
        m_tenure++;
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  int wait_cyc [4] = '{0, 0, 0, 0};

  initial begin
    forever begin
      @(posedge clk);
      #2;
      check("G_vs_model", G, m_busy ? (1 << m_owner) : 0);
      check("V_vs_model", V, m_busy);
      if (m_busy) check("S_vs_model", S, m_owner);
      check("Y_vs_model", Y, m_busy ? I[m_owner] : 0);
      check("G_onehot", $countones(G) <= 1, 1);
      check("V_eq_orG", V, |G);
      for (int k = 0; k < 4; k++) begin
        if (!rst && R[k] && !G[k]) wait_cyc[k]++;
        else wait_cyc[k] = 0;
        if (R[k]) check("starvation_bound", wait_cyc[k] <= 3*MH + 3, 1);
      end
    end
  end

  // ---------------- directed + random stimulus ----------------
  task automatic do_reset();
    @(negedge clk); rst = 1'b1; R = 4'b0000;
    @(negedge clk); rst = 1'b0;
  endtask

  initial begin
    // Test 1: single request on index 2, then release.
    @(negedge clk);
    check("reset_G", G, 0);
    check("reset_V", V, 0);
    check("reset_S", S, 0);
    check("reset_Y", Y, 0);
    rst = 1'b0;
    R = 4'b0100; I = 4'b0100;
    @(negedge clk);
    check("t1_G", G, 4'b0100);
    check("t1_S", S, 2);
    check("t1_V", V, 1);
    check("t1_Y", Y, 1);
    R = 4'b0000;
    @(negedge clk);
    check("t1_rel_G", G, 0);
    check("t1_rel_V", V, 0);
    check("t1_rel_Y", Y, 0);

    // Test 2: pointer sits at 3, so 3 wins, then wrap-around handoffs.
    R = 4'b1111;
    @(negedge clk);
    check("t2_win3", G, 4'b1000);
    R = 4'b0111;
    @(negedge clk);
    check("t2_hand0", G, 4'b0001);
    check("t2_hand0_V", V, 1);
    R = 4'b0110;
    @(negedge clk);
    check("t2_hand1", G, 4'b0010);
    R = 4'b0100;
    @(negedge clk);
    check("t2_hand2", G, 4'b0100);
    check("t2_hand2_V", V, 1);
    R = 4'b0000;
    @(negedge clk);

    // Test 3: two contenders alternate in blocks of MH cycles.
    do_reset();
    R = 4'b0011;
    for (int i = 0; i < 4*MH; i++) begin
      @(negedge clk);
      check("t3_alternate", G, ((i / MH) % 2 == 0) ? 4'b0001 : 4'b0010);
    end
    R = 4'b0000;
    @(negedge clk);

    // Test 4: lone requester keeps the line, then yields to a newcomer.
    do_reset();
    R = 4'b0001;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("t4_hold", G, 4'b0001);
    end
    R = 4'b0101;
    @(negedge clk);
    check("t4_yield", G, 4'b0100);
    R = 4'b0000;
    @(negedge clk);

    // Test 5: asynchronous reset mid-grant, then pointer back at 0.
    do_reset();
    R = 4'b0010; I = 4'b1111;
    @(negedge clk);
    check("t5_pre_G", G, 4'b0010);
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    check("t5_rst_G", G, 0);
    check("t5_rst_V", V, 0);
    check("t5_rst_S", S, 0);
    check("t5_rst_Y", Y, 0);
    @(negedge clk);
    R = 4'b1010; rst = 1'b0;
    @(negedge clk);
    check("t5_after_G", G, 4'b0010);
    check("t5_after_S", S, 1);
    I = 4'b1101;
    #1;
    check("t5_Y_comb", Y, 0);
    R = 4'b0000;
    @(negedge clk);

    // Test 6: random traffic with sticky request lines.
    for (int c = 0; c < 10000; c++) begin
      @(negedge clk);
      for (int k = 0; k < 4; k++)
        if ($urandom_range(7) == 0) R[k] = ~R[k];
      I = 4'($urandom);
    end
    R = 4'b0000;
    @(negedge clk);
    @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
